// File: rtl/linear_processing_element_pkg.sv
// rtl/linear_processing_element_pkg.sv - shared types and helpers for the linear processing element
//
// Package lpe_pkg:
//   up_class_e       : classification of a beat arriving on the up port
//   lpe_classify     : maps the OP1/RSLT tuser flags onto up_class_e
//   lpe_align_narrow : shifts a wide accumulator into the result format and
//                      narrows it (saturating when LPE_SATURATE_EN is defined,
//                      otherwise the caller keeps the low bits, i.e. wraps)
//   lpe_result_tag   : builds the tuser tag attached to an own result beat
package lpe_pkg;

   typedef enum logic [1:0] {
      UP_OP1,
      UP_RSLT,
      UP_ILLEGAL
   } up_class_e;

   // Working width for alignment; the accumulator must not exceed it.
   localparam int ALIGN_W = 64;

   function automatic up_class_e lpe_classify(input logic op1_flag, input logic rslt_flag);
      if (op1_flag && !rslt_flag) return UP_OP1;
      if (rslt_flag && !op1_flag) return UP_RSLT;
      return UP_ILLEGAL;
   endfunction

   // Arithmetic right shift floors, which gives truncation toward -inf.
   function automatic logic signed [ALIGN_W-1:0] lpe_align_narrow(
      input logic signed [ALIGN_W-1:0] acc,
      input int shift,
      input int width
   );
      logic signed [ALIGN_W-1:0] v;
`ifdef LPE_SATURATE_EN
      logic signed [ALIGN_W-1:0] max_v;
      logic signed [ALIGN_W-1:0] min_v;
`endif
      v = (shift >= 0) ? (acc >>> shift) : (acc <<< (-shift));
`ifdef LPE_SATURATE_EN
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (v > max_v) v = max_v;
      else if (v < min_v) v = min_v;
`else
      if (width < 0) v = '0;
`endif
      return v;
   endfunction

   function automatic logic [31:0] lpe_result_tag(
      input int rslt_mask,
      input int user_width,
      input int dest,
      input int id
   );
      return 32'(rslt_mask | (dest << ((user_width - 2) / 2)) | id);
   endfunction

endpackage

// File: rtl/linear_processing_element_if.sv
// rtl/linear_processing_element_if.sv - stream interface used on all four ports of the cell
//
// Signals: tdata[DATA_W], tvalid, tready, tlast, tuser[USER_W]
// Modports: master drives tdata/tvalid/tlast/tuser and samples tready;
//           slave is the mirror image.
interface linear_processing_element_if #(
   parameter int DATA_W = 16,
   parameter int USER_W = 8
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [USER_W-1:0] tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/linear_processing_element_mac.sv
// rtl/linear_processing_element_mac.sv - multiply-accumulate core of the processing element
//
// Module lpe_mac
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : a pair is consumed this cycle
//   last_i     : the consumed pair closes the frame
//   op0_i/op1_i: raw operands (zero- or sign-extended per IS_UNSIGNED_*)
//   result_o   : aligned, narrowed frame result, updated on the last pair
module lpe_mac
   import lpe_pkg::*;
#(
   parameter int DATA_WIDTH_OP0       = 16,
   parameter int FRACTIONAL_BITS_OP0  = 12,
   parameter bit IS_UNSIGNED_OP0      = 1'b0,
   parameter int DATA_WIDTH_OP1       = 16,
   parameter int FRACTIONAL_BITS_OP1  = 12,
   parameter bit IS_UNSIGNED_OP1      = 1'b0,
   parameter int DATA_WIDTH_RSLT      = 16,
   parameter int FRACTIONAL_BITS_RSLT = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en_i,
   input  logic                       last_i,
   input  logic [DATA_WIDTH_OP0-1:0]  op0_i,
   input  logic [DATA_WIDTH_OP1-1:0]  op1_i,
   output logic [DATA_WIDTH_RSLT-1:0] result_o
);
   localparam int PROD_W = DATA_WIDTH_OP0 + DATA_WIDTH_OP1 + 2;
   localparam int ACC_W  = DATA_WIDTH_OP0 + DATA_WIDTH_OP1 + 8;
   localparam int SHIFT  = FRACTIONAL_BITS_OP0 + FRACTIONAL_BITS_OP1 - FRACTIONAL_BITS_RSLT;

   // One extra bit lets unsigned operands share the signed multiplier.
   logic signed [DATA_WIDTH_OP0:0] op0_ext;
   logic signed [DATA_WIDTH_OP1:0] op1_ext;
   logic signed [PROD_W-1:0]       prod;
   logic signed [ACC_W-1:0]        sum;
   logic signed [ALIGN_W-1:0]      sum_wide;
   logic signed [ALIGN_W-1:0]      aligned;
   logic                           unused_aligned_hi;

   logic signed [ACC_W-1:0]        acc_q, acc_d;
   logic [DATA_WIDTH_RSLT-1:0]     result_q, result_d;

   assign op0_ext  = IS_UNSIGNED_OP0 ? {1'b0, op0_i} : {op0_i[DATA_WIDTH_OP0-1], op0_i};
   assign op1_ext  = IS_UNSIGNED_OP1 ? {1'b0, op1_i} : {op1_i[DATA_WIDTH_OP1-1], op1_i};
   assign prod     = op0_ext * op1_ext;
   assign sum      = acc_q + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
   assign sum_wide = $signed({{(ALIGN_W-ACC_W){sum[ACC_W-1]}}, sum});
   assign aligned  = lpe_align_narrow(sum_wide, SHIFT, DATA_WIDTH_RSLT);
   assign unused_aligned_hi = ^aligned[ALIGN_W-1:DATA_WIDTH_RSLT];

   always_comb begin
      acc_d    = acc_q;
      result_d = result_q;
      if (en_i) begin
         if (last_i) begin
            acc_d    = '0;
            result_d = aligned[DATA_WIDTH_RSLT-1:0];
         end else begin
            acc_d    = sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign result_o = result_q;
endmodule

// File: rtl/linear_processing_element.sv
// rtl/linear_processing_element.sv - one cell of a systolic matrix-vector array
//
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   s_axis_up (slave)   : op1 beats (tuser OP1 flag) or upstream results (RSLT flag)
//   s_axis_left (slave) : op0 beats
//   m_axis_down (master): forwarded op1 / upstream results / own result
//   m_axis_right(master): forwarded op0
//   err_unalligned_data : sticky, paired beats disagreed on tlast
//   err_user_flag       : sticky, up beat carried both or neither flag
// Build option: LPE_SATURATE_EN selects saturating result narrowing.
module linear_processing_element
   import lpe_pkg::*;
#(
   parameter int PE_NUMBER_I          = 1,
   parameter int PE_NUMBER_J          = 1,
   parameter int PE_POSITION_I        = 0,
   parameter int PE_POSITION_J        = 0,
   parameter int DATA_WIDTH_OP0       = 16,
   parameter int FRACTIONAL_BITS_OP0  = 12,
   parameter bit IS_UNSIGNED_OP0      = 1'b0,
   parameter int DATA_WIDTH_OP1       = 16,
   parameter int FRACTIONAL_BITS_OP1  = 12,
   parameter bit IS_UNSIGNED_OP1      = 1'b0,
   parameter int DATA_WIDTH_RSLT      = 16,
   parameter int FRACTIONAL_BITS_RSLT = 12,
   parameter int USER_WIDTH           = 8,
   parameter int OUTPUT_DEST          = 1,
   parameter int OUTPUT_ID            = 1,
   parameter int DATA_WIDTH_U_D       = (DATA_WIDTH_OP1 > DATA_WIDTH_RSLT) ? DATA_WIDTH_OP1 : DATA_WIDTH_RSLT,
   parameter int DATA_WIDTH_L_R       = 16,
   parameter int OP1_USER_MASK        = 1 << (USER_WIDTH - 2),
   parameter int RSLT_USER_MASK       = 1 << (USER_WIDTH - 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   linear_processing_element_if.slave  s_axis_up,
   linear_processing_element_if.slave  s_axis_left,
   linear_processing_element_if.master m_axis_down,
   linear_processing_element_if.master m_axis_right,
   output logic                        err_unalligned_data,
   output logic                        err_user_flag
);
   localparam bit LAST_ROW = (PE_POSITION_I == PE_NUMBER_I - 1);
   localparam bit LAST_COL = (PE_POSITION_J == PE_NUMBER_J - 1);
   localparam logic [USER_WIDTH-1:0] OP1_M  = USER_WIDTH'(OP1_USER_MASK);
   localparam logic [USER_WIDTH-1:0] RSLT_M = USER_WIDTH'(RSLT_USER_MASK);
   localparam logic [USER_WIDTH-1:0] RSLT_TAG =
      USER_WIDTH'(lpe_result_tag(RSLT_USER_MASK, USER_WIDTH, OUTPUT_DEST, OUTPUT_ID));

   up_class_e up_class;
   logic right_free, down_free;
   logic pair_fire, rslt_fire, drop_fire, pair_last;
   logic [DATA_WIDTH_RSLT-1:0] mac_result;
   logic unused_left_user;

   logic                      down_valid_q, down_valid_d;
   logic [DATA_WIDTH_U_D-1:0] down_data_q,  down_data_d;
   logic                      down_last_q,  down_last_d;
   logic [USER_WIDTH-1:0]     down_user_q,  down_user_d;
   logic                      right_valid_q, right_valid_d;
   logic [DATA_WIDTH_L_R-1:0] right_data_q,  right_data_d;
   logic                      right_last_q,  right_last_d;
   logic                      pend_q, pend_d;
   logic                      err_unal_q, err_unal_d;
   logic                      err_user_q, err_user_d;

   assign unused_left_user = ^s_axis_left.tuser;
   assign up_class = lpe_classify(|(s_axis_up.tuser & OP1_M), |(s_axis_up.tuser & RSLT_M));

   // Last column has no right neighbour, so the right register never blocks;
   // last row drops op1, so a pair does not need the down register then.
   assign right_free = LAST_COL || !right_valid_q || m_axis_right.tready;
   assign down_free  = !down_valid_q || m_axis_down.tready;

   assign pair_fire = s_axis_left.tvalid && s_axis_up.tvalid && (up_class == UP_OP1) &&
                      !pend_q && right_free && (LAST_ROW || down_free);
   assign rslt_fire = s_axis_up.tvalid && (up_class == UP_RSLT) && !pend_q && down_free;
   assign drop_fire = s_axis_up.tvalid && (up_class == UP_ILLEGAL) && !pend_q;
   assign pair_last = s_axis_left.tlast || s_axis_up.tlast;

   assign s_axis_left.tready = pair_fire;
   assign s_axis_up.tready   = pair_fire || rslt_fire || drop_fire;

   lpe_mac #(
      .DATA_WIDTH_OP0      (DATA_WIDTH_OP0),
      .FRACTIONAL_BITS_OP0 (FRACTIONAL_BITS_OP0),
      .IS_UNSIGNED_OP0     (IS_UNSIGNED_OP0),
      .DATA_WIDTH_OP1      (DATA_WIDTH_OP1),
      .FRACTIONAL_BITS_OP1 (FRACTIONAL_BITS_OP1),
      .IS_UNSIGNED_OP1     (IS_UNSIGNED_OP1),
      .DATA_WIDTH_RSLT     (DATA_WIDTH_RSLT),
      .FRACTIONAL_BITS_RSLT(FRACTIONAL_BITS_RSLT)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst),
      .en_i    (pair_fire),
      .last_i  (pair_last),
      .op0_i   (s_axis_left.tdata[DATA_WIDTH_OP0-1:0]),
      .op1_i   (s_axis_up.tdata[DATA_WIDTH_OP1-1:0]),
      .result_o(mac_result)
   );

   always_comb begin
      down_valid_d  = down_valid_q;
      down_data_d   = down_data_q;
      down_last_d   = down_last_q;
      down_user_d   = down_user_q;
      right_valid_d = right_valid_q;
      right_data_d  = right_data_q;
      right_last_d  = right_last_q;
      // A pending own result waits until the down register frees up.
      pend_d        = pend_q ? !down_free : (pair_fire && pair_last);
      err_unal_d    = err_unal_q || (pair_fire && (s_axis_left.tlast != s_axis_up.tlast));
      err_user_d    = err_user_q || drop_fire;

      if (down_free) begin
         down_valid_d = 1'b0;
         if (pend_q) begin
            down_valid_d = 1'b1;
            down_data_d  = DATA_WIDTH_U_D'($signed(mac_result));
            down_last_d  = 1'b1;
            down_user_d  = RSLT_TAG;
         end else if ((pair_fire && !LAST_ROW) || rslt_fire) begin
            down_valid_d = 1'b1;
            down_data_d  = s_axis_up.tdata;
            down_last_d  = s_axis_up.tlast;
            down_user_d  = s_axis_up.tuser;
         end
      end

      if (right_free) begin
         right_valid_d = 1'b0;
         if (pair_fire && !LAST_COL) begin
            right_valid_d = 1'b1;
            right_data_d  = s_axis_left.tdata;
            right_last_d  = s_axis_left.tlast;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         down_valid_q  <= 1'b0;
         down_data_q   <= '0;
         down_last_q   <= 1'b0;
         down_user_q   <= '0;
         right_valid_q <= 1'b0;
         right_data_q  <= '0;
         right_last_q  <= 1'b0;
         pend_q        <= 1'b0;
         err_unal_q    <= 1'b0;
         err_user_q    <= 1'b0;
      end else begin
         down_valid_q  <= down_valid_d;
         down_data_q   <= down_data_d;
         down_last_q   <= down_last_d;
         down_user_q   <= down_user_d;
         right_valid_q <= right_valid_d;
         right_data_q  <= right_data_d;
         right_last_q  <= right_last_d;
         pend_q        <= pend_d;
         err_unal_q    <= err_unal_d;
         err_user_q    <= err_user_d;
      end
   end

   assign m_axis_down.tvalid  = down_valid_q;
   assign m_axis_down.tdata   = down_data_q;
   assign m_axis_down.tlast   = down_last_q;
   assign m_axis_down.tuser   = down_user_q;
   assign m_axis_right.tvalid = right_valid_q;
   assign m_axis_right.tdata  = right_data_q;
   assign m_axis_right.tlast  = right_last_q;
   assign m_axis_right.tuser  = '0;
   assign err_unalligned_data = err_unal_q;
   assign err_user_flag       = err_user_q;
endmodule

// File: tb/tb_linear_processing_element.sv
// tb/tb_linear_processing_element.sv - self-checking bench for linear_processing_element (2x2 grid, cell 0,0)
module tb_linear_processing_element;
   logic clk = 1'b0;
   logic rst;
   logic err_unal, err_user;
   always #5 clk = ~clk;

   linear_processing_element_if #(.DATA_W(16), .USER_W(8)) up_if ();
   linear_processing_element_if #(.DATA_W(16), .USER_W(8)) left_if ();
   linear_processing_element_if #(.DATA_W(16), .USER_W(8)) down_if ();
   linear_processing_element_if #(.DATA_W(16), .USER_W(8)) right_if ();

   linear_processing_element #(.PE_NUMBER_I(2), .PE_NUMBER_J(2)) dut (
      .clk                (clk),
      .rst                (rst),
      .s_axis_up          (up_if),
      .s_axis_left        (left_if),
      .m_axis_down        (down_if),
      .m_axis_right       (right_if),
      .err_unalligned_data(err_unal),
      .err_user_flag      (err_user)
   );

   int checks = 0;
   int errors = 0;
   logic [24:0] got_down[$];
   logic [24:0] exp_down[$];
   logic [16:0] got_right[$];
   logic [16:0] exp_right[$];
   longint acc_m = 0;
   bit err_unal_m = 0;
   bit err_user_m = 0;
   bit done = 0;

   // Record every beat that the next rising edge will transfer.
   always @(negedge clk) begin
      if (rst && down_if.tvalid && down_if.tready)
         got_down.push_back({down_if.tuser, down_if.tlast, down_if.tdata});
      if (rst && right_if.tvalid && right_if.tready)
         got_right.push_back({right_if.tlast, right_if.tdata});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int rnd16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   // Q4.12 * Q4.12 sum -> Q4.12: floor division by 2^12, then narrow to 16 bits.
   function automatic logic [15:0] model_result(input longint sum);
      longint q;
      q = sum / 4096;
      if (sum < 0 && q * 4096 != sum) q = q - 1;
`ifdef LPE_SATURATE_EN
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
`endif
      return q[15:0];
   endfunction

   task automatic send_pair(input int op0, input bit l0, input int op1, input bit l1);
      bit ok;
      left_if.tdata = 16'(op0); left_if.tlast = l0; left_if.tvalid = 1'b1;
      up_if.tdata = 16'(op1); up_if.tlast = l1; up_if.tuser = 8'h40; up_if.tvalid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (left_if.tready && up_if.tready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      left_if.tvalid = 1'b0; up_if.tvalid = 1'b0;
      chk("pair handshake", 32'(ok), 32'd1);
      if (ok) begin
         exp_right.push_back({l0, 16'(op0)});
         exp_down.push_back({8'h40, l1, 16'(op1)});
         acc_m += longint'(op0) * longint'(op1);
         if (l0 != l1) err_unal_m = 1'b1;
         if (l0 || l1) begin
            exp_down.push_back({8'h89, 1'b1, model_result(acc_m)});
            acc_m = 0;
         end
      end
   endtask

   task automatic send_up(input logic [15:0] data, input logic [7:0] user, input bit last);
      bit ok;
      up_if.tdata = data; up_if.tuser = user; up_if.tlast = last; up_if.tvalid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (up_if.tready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      up_if.tvalid = 1'b0;
      chk("up handshake", 32'(ok), 32'd1);
      if (ok) begin
         if (user[7] && !user[6]) exp_down.push_back({user, last, data});
         else if (user[7] == user[6]) err_user_m = 1'b1;
      end
   endtask

   task automatic compare_streams(input string tag);
      repeat (6) @(posedge clk);
      #1;
      chk({tag, " down count"}, 32'(got_down.size()), 32'(exp_down.size()));
      for (int i = 0; i < got_down.size() && i < exp_down.size(); i++)
         chk({tag, " down beat"}, 32'(got_down[i]), 32'(exp_down[i]));
      chk({tag, " right count"}, 32'(got_right.size()), 32'(exp_right.size()));
      for (int i = 0; i < got_right.size() && i < exp_right.size(); i++)
         chk({tag, " right beat"}, 32'(got_right[i]), 32'(exp_right[i]));
      got_down.delete(); exp_down.delete(); got_right.delete(); exp_right.delete();
   endtask

   initial begin
      int vals[5];
      int len;
      vals[0] = -16384; vals[1] = -4096; vals[2] = 0; vals[3] = 4096; vals[4] = 16384;
      rst = 1'b0;
      up_if.tvalid = 1'b0; up_if.tdata = '0; up_if.tlast = 1'b0; up_if.tuser = '0;
      left_if.tvalid = 1'b0; left_if.tdata = '0; left_if.tlast = 1'b0; left_if.tuser = '0;
      down_if.tready = 1'b1; right_if.tready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset down tvalid", 32'(down_if.tvalid), 32'd0);
      chk("reset right tvalid", 32'(right_if.tvalid), 32'd0);
      chk("reset up tready", 32'(up_if.tready), 32'd0);
      chk("reset left tready", 32'(left_if.tready), 32'd0);
      chk("reset down tdata/tuser/tlast", {7'd0, down_if.tuser, down_if.tlast, down_if.tdata}, 32'd0);
      chk("reset err flags", {30'd0, err_unal, err_user}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Two back-to-back 25-beat frames whose sum is zero.
      for (int f = 0; f < 2; f++)
         for (int b = 0; b < 25; b++)
            send_pair(vals[b % 5], b == 24, vals[b / 5], b == 24);
      compare_streams("zero frames");

      send_pair(4096, 1'b0, 8192, 1'b0);
      send_pair(8192, 1'b0, 2048, 1'b0);
      send_pair(-4096, 1'b1, 4096, 1'b1);
      repeat (6) @(posedge clk); #1;
      chk("3-beat result", 32'(got_down.size() > 0 ? got_down[got_down.size()-1] : 25'd0),
          {7'd0, 8'h89, 1'b1, 16'd8192});
      compare_streams("3-beat");

      for (int b = 0; b < 25; b++) send_pair(4096, b == 24, 4096, b == 24);
      repeat (6) @(posedge clk); #1;
`ifdef LPE_SATURATE_EN
      chk("overflow result", 32'(got_down.size() > 0 ? got_down[got_down.size()-1][15:0] : 16'd0), 32'd32767);
`else
      chk("overflow result", 32'(got_down.size() > 0 ? got_down[got_down.size()-1][15:0] : 16'd0), 32'd36864);
`endif
      compare_streams("overflow");

      // op1 tlast one beat before op0 tlast.
      send_pair(4096, 1'b0, 4096, 1'b0);
      send_pair(8192, 1'b0, 4096, 1'b1);
      chk("unaligned flag after beat 2", 32'(err_unal), 32'(err_unal_m));
      send_pair(4096, 1'b1, -8192, 1'b0);
      compare_streams("unaligned");

      send_up(16'hBEEF, 8'h00, 1'b0);
      send_up(16'hBEEF, 8'hC0, 1'b0);
      chk("user flag after illegal", 32'(err_user), 32'(err_user_m));
      send_up(16'h1234, 8'h83, 1'b1);
      compare_streams("rslt passthrough");
      chk("unaligned flag held", 32'(err_unal), 32'(err_unal_m));

      // down_tready held low for 10 cycles mid-frame.
      fork
         for (int b = 0; b < 8; b++) send_pair(rnd16(), b == 7, rnd16(), b == 7);
         begin
            repeat (4) @(posedge clk);
            #2 down_if.tready = 1'b0;
            repeat (10) @(posedge clk);
            #2 down_if.tready = 1'b1;
         end
      join
      compare_streams("down stall");

      // Random frames with random back-pressure on both outputs.
      done = 1'b0;
      fork
         begin
            for (int f = 0; f < 6; f++) begin
               len = int'($urandom_range(1, 10));
               for (int b = 0; b < len; b++) send_pair(rnd16(), b == len - 1, rnd16(), b == len - 1);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #2;
               down_if.tready = ($urandom_range(0, 3) != 0);
               right_if.tready = ($urandom_range(0, 3) != 0);
            end
            down_if.tready = 1'b1; right_if.tready = 1'b1;
         end
      join
      compare_streams("random frames");

      // Reset mid-frame discards the partial sum and the sticky flags.
      send_pair(16384, 1'b0, 16384, 1'b0);
      send_pair(16384, 1'b0, 16384, 1'b0);
      compare_streams("partial frame");
      rst = 1'b0;
      acc_m = 0; err_unal_m = 1'b0; err_user_m = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid-frame reset err flags", {30'd0, err_unal, err_user}, 32'd0);
      chk("mid-frame reset down tvalid", 32'(down_if.tvalid), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      send_pair(4096, 1'b1, 4096, 1'b1);
      compare_streams("after reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
